// File: rtl/board_move_ctrl.sv
// Connect-four move controller: column selection, landing, draw handshake.
// Define WIN_CHECK_EN to enable vertical/horizontal four-in-a-row detection.
module board_move_ctrl (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move_valid,
  input  logic [2:0] col_sel,
  output logic       move_ready,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [2:0] draw_location,
  output logic [2:0] draw_height,
  output logic       draw_player,
  output logic       cur_player,
  output logic [6:0] col_full,
  output logic       illegal,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE, CHECK, UPDATE, DRAW, WIN, OVER
  } state_t;

  state_t     state, state_nx;
  logic [5:0] occ    [7];
  logic [5:0] own    [7];
  logic [2:0] height [7];
  logic [2:0] col_q;
  logic [7:0] blocked;
  logic       full;
  logic       win_hit;

  always_comb begin
    for (int c = 0; c < 7; c++)
      col_full[c] = (height[c] == 3'd6);
  end

  // column 7 is always blocked
  assign blocked = {1'b1, col_full};
  assign full    = &col_full;

`ifdef WIN_CHECK_EN
  logic [5:0] vbits;
  logic [6:0] hbits;

  always_comb begin
    vbits = occ[draw_location] &
      (draw_player ? own[draw_location] : ~own[draw_location]);
    for (int c = 0; c < 7; c++)
      hbits[c] = occ[c][draw_height] &&
        (own[c][draw_height] == draw_player);
    win_hit = (&vbits[3:0]) | (&vbits[4:1]) | (&vbits[5:2]) |
              (&hbits[3:0]) | (&hbits[4:1]) | (&hbits[5:2]) |
              (&hbits[6:3]);
  end
`else
  logic unused_own;
  assign unused_own = ^{own[0], own[1], own[2], own[3],
                        own[4], own[5], own[6]};
  assign win_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    illegal  = 1'b0;
    unique case (state)
      IDLE:   if (move_valid) state_nx = CHECK;
      CHECK: begin
        if (blocked[col_q]) begin
          illegal  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = UPDATE;
        end
      end
      UPDATE: state_nx = DRAW;
      DRAW:   if (draw_ack) state_nx = WIN;
      WIN:    state_nx = (win_hit || full) ? OVER : IDLE;
      OVER:   state_nx = OVER;
      default: state_nx = IDLE;
    endcase
  end

  assign move_ready = (state == IDLE);
  assign draw_req   = (state == DRAW);
  assign game_over  = (state == OVER);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      col_q         <= 3'd0;
      cur_player    <= 1'b0;
      draw_location <= 3'd0;
      draw_height   <= 3'd0;
      draw_player   <= 1'b0;
      winner        <= 1'b0;
      for (int c = 0; c < 7; c++) begin
        occ[c]    <= 6'd0;
        own[c]    <= 6'd0;
        height[c] <= 3'd0;
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && move_valid)
        col_q <= col_sel;
      if (state == UPDATE && height[col_q] != 3'd6) begin
        occ[col_q][height[col_q]] <= 1'b1;
        own[col_q][height[col_q]] <= cur_player;
        height[col_q]             <= height[col_q] + 3'd1;
        draw_location             <= col_q;
        draw_height               <= height[col_q];
        draw_player               <= cur_player;
      end
      if (state == DRAW && draw_ack)
        cur_player <= ~cur_player;
      if (state == WIN && win_hit)
        winner <= draw_player;
    end
  end

endmodule
